// File: rtl/mips_mc_pkg.sv
// Shared types and constants for the multi-cycle MIPS main control FSM.
// Optional addi support is selected by the MC_CTRL_ADDI_EN macro.
package mips_mc_pkg;

    localparam int unsigned STATE_W  = 4;
    localparam int unsigned OPCODE_W = 6;
    localparam int unsigned SEL_W    = 2;

    // ADDIEX/ADDIWB encodings are reserved even when addi support is not built.
    typedef enum logic [STATE_W-1:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWR  = 4'd4,
        S_MEMWB  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_JUMP   = 4'd9,
        S_ADDIEX = 4'd10,
        S_ADDIWB = 4'd11
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OPCODE_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OPCODE_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OPCODE_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OPCODE_W-1:0] OP_J     = 6'b000010;
    localparam logic [OPCODE_W-1:0] OP_ADDI  = 6'b001000;

    localparam logic [SEL_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [SEL_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [SEL_W-1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [SEL_W-1:0] SRCB_REGB    = 2'b00;
    localparam logic [SEL_W-1:0] SRCB_FOUR    = 2'b01;
    localparam logic [SEL_W-1:0] SRCB_IMM     = 2'b10;
    localparam logic [SEL_W-1:0] SRCB_IMM_SH2 = 2'b11;

    localparam logic [SEL_W-1:0] PCSRC_ALU    = 2'b00;
    localparam logic [SEL_W-1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [SEL_W-1:0] PCSRC_JUMP   = 2'b10;

    // Full datapath control word produced per state.
    typedef struct packed {
        logic             mem_req;
        logic             iord;
        logic             mem_write;
        logic             ir_write;
        logic             pc_write;
        logic             branch;
        logic [SEL_W-1:0] pc_src;
        logic             alu_src_a;
        logic [SEL_W-1:0] alu_src_b;
        logic [SEL_W-1:0] alu_op;
        logic             reg_dst;
        logic             mem_to_reg;
        logic             reg_write;
    } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control-word decoder for the multi-cycle control FSM.
// ADDIEX/ADDIWB decode only exists when MC_CTRL_ADDI_EN is defined.
module mc_ctrl_decode
    import mips_mc_pkg::*;
(
    input  logic   [STATE_W-1:0] state,
    input  logic                 mem_ready,
    output ctrl_t                ctrl_c
);

    always_comb begin
        ctrl_c = '0;
        case (state_t'(state))
            S_FETCH: begin
                ctrl_c.mem_req   = 1'b1;
                ctrl_c.iord      = 1'b0;
                ctrl_c.alu_src_a = 1'b0;
                ctrl_c.alu_src_b = SRCB_FOUR;
                ctrl_c.alu_op    = ALUOP_ADD;
                ctrl_c.pc_src    = PCSRC_ALU;
                // IR and PC only advance on the cycle the fetch completes.
                ctrl_c.ir_write  = mem_ready;
                ctrl_c.pc_write  = mem_ready;
            end
            S_DECODE: begin
                ctrl_c.alu_src_a = 1'b0;
                ctrl_c.alu_src_b = SRCB_IMM_SH2;
                ctrl_c.alu_op    = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALUOP_ADD;
            end
            S_MEMRD: begin
                ctrl_c.mem_req = 1'b1;
                ctrl_c.iord    = 1'b1;
            end
            S_MEMWR: begin
                ctrl_c.mem_req   = 1'b1;
                ctrl_c.iord      = 1'b1;
                ctrl_c.mem_write = 1'b1;
            end
            S_MEMWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.mem_to_reg = 1'b1;
                ctrl_c.reg_dst    = 1'b0;
            end
            S_EXEC: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_REGB;
                ctrl_c.alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.reg_dst    = 1'b1;
                ctrl_c.mem_to_reg = 1'b0;
            end
            S_BRANCH: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_REGB;
                ctrl_c.alu_op    = ALUOP_SUB;
                ctrl_c.pc_src    = PCSRC_ALUOUT;
                ctrl_c.branch    = 1'b1;
            end
            S_JUMP: begin
                ctrl_c.pc_src   = PCSRC_JUMP;
                ctrl_c.pc_write = 1'b1;
            end
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: begin
                ctrl_c.alu_src_a = 1'b1;
                ctrl_c.alu_src_b = SRCB_IMM;
                ctrl_c.alu_op    = ALUOP_ADD;
            end
            S_ADDIWB: begin
                ctrl_c.reg_write  = 1'b1;
                ctrl_c.reg_dst    = 1'b0;
                ctrl_c.mem_to_reg = 1'b0;
            end
`endif
            default: ctrl_c = '0;
        endcase
    end

endmodule

// File: rtl/mips_mc_ctrl.sv
// Multi-cycle MIPS main control FSM: state register, opcode dispatch and reset gating.
// Define MC_CTRL_ADDI_EN to build the addi path (ADDIEX/ADDIWB).
module mips_mc_ctrl
    import mips_mc_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    input  logic                mem_ready,
    output logic                mem_req,
    output logic                iord,
    output logic                mem_write,
    output logic                ir_write,
    output logic                pc_write,
    output logic                branch,
    output logic [SEL_W-1:0]    pc_src,
    output logic                alu_src_a,
    output logic [SEL_W-1:0]    alu_src_b,
    output logic [SEL_W-1:0]    alu_op,
    output logic                reg_dst,
    output logic                mem_to_reg,
    output logic                reg_write,
    output logic                illegal_op,
    output logic [STATE_W-1:0]  state
);

    state_t state_q;
    state_t state_d;
    logic   illegal_c;
    ctrl_t  ctrl_c;
    ctrl_t  ctrl_g;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state dispatch; opcode is only looked at in DECODE and MEMADR.
    always_comb begin
        state_d   = S_FETCH;
        illegal_c = 1'b0;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_J:         state_d = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`else
                    OP_ADDI: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
`endif
                    default: begin
                        state_d   = S_FETCH;
                        illegal_c = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (opcode == OP_LW) begin
                    state_d = S_MEMRD;
                end else if (opcode == OP_SW) begin
                    state_d = S_MEMWR;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
`ifdef MC_CTRL_ADDI_EN
            S_ADDIEX: state_d = S_ADDIWB;
`endif
            default:  state_d = S_FETCH;
        endcase
    end

    mc_ctrl_decode u_decode (
        .state     (STATE_W'(state_q)),
        .mem_ready (mem_ready),
        .ctrl_c    (ctrl_c)
    );

    // Reset wins over everything so an aborted access never strobes a write.
    assign ctrl_g = rst ? '0 : ctrl_c;

    assign mem_req    = ctrl_g.mem_req;
    assign iord       = ctrl_g.iord;
    assign mem_write  = ctrl_g.mem_write;
    assign ir_write   = ctrl_g.ir_write;
    assign pc_write   = ctrl_g.pc_write;
    assign branch     = ctrl_g.branch;
    assign pc_src     = ctrl_g.pc_src;
    assign alu_src_a  = ctrl_g.alu_src_a;
    assign alu_src_b  = ctrl_g.alu_src_b;
    assign alu_op     = ctrl_g.alu_op;
    assign reg_dst    = ctrl_g.reg_dst;
    assign mem_to_reg = ctrl_g.mem_to_reg;
    assign reg_write  = ctrl_g.reg_write;
    assign illegal_op = illegal_c & ~rst;
    assign state      = rst ? STATE_W'(0) : STATE_W'(state_q);

endmodule

// File: doc/mips_mc_ctrl.md
# mips_mc_ctrl

Multi-cycle main control FSM for the 32-bit MIPS core. It decodes the 6-bit opcode, sequences each instruction through fetch, decode, execute, memory and write-back states, and drives every datapath enable and mux select. It sits directly upstream of the ALU control unit and supplies its 2-bit `alu_op` (00 add, 01 sub, 10 use funct). It also handshakes with instruction/data memory through a req/ready pair.

## Interface
- No parameters; state encoding and opcodes live in the package.
- `clk` in 1: single clock; all state changes on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `opcode` in 6: instruction bits [31:26] from the instruction register; valid from DECODE onward.
- `mem_ready` in 1: memory completes the current access this cycle.
- `mem_req` out 1: memory access request.
- `iord` out 1: address mux; 0 = PC, 1 = ALU out.
- `mem_write` out 1: write strobe, qualified by `mem_req`.
- `ir_write` out 1: load the instruction register.
- `pc_write` out 1: unconditional PC load.
- `branch` out 1: PC load if ALU zero.
- `pc_src` out 2: 00 = ALU result, 01 = ALU out register, 10 = jump target.
- `alu_src_a` out 1: 0 = PC, 1 = register A.
- `alu_src_b` out 2: 00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `alu_op` out 2: to the ALU control unit.
- `reg_dst` out 1: 0 = rt, 1 = rd.
- `mem_to_reg` out 1: 0 = ALU out, 1 = memory data.
- `reg_write` out 1: register-file write enable.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `state` out 4: current state, for debug only.

## Operation
- Moore FSM with one 4-bit state register. Outputs are a decode of the state, except `ir_write` and `pc_write` in FETCH, which are gated by `mem_ready`.
- Any output not listed for a state is 0.

States and outputs:
- FETCH: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_src`=00, `ir_write`=`pc_write`=`mem_ready`.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00 (branch target precompute).
- MEMADR: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
- MEMRD: `mem_req`=1, `iord`=1.
- MEMWR: `mem_req`=1, `iord`=1, `mem_write`=1.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
- EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
- ALUWB: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `pc_src`=01, `branch`=1.
- JUMP: `pc_src`=10, `pc_write`=1.
- ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
- ADDIWB: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=0.

Transitions:
- FETCH → DECODE when `mem_ready`; otherwise stay in FETCH.
- DECODE dispatches on opcode:
  - 000000 → EXEC
  - 100011 / 101011 → MEMADR
  - 000100 → BRANCH
  - 000010 → JUMP
  - 001000 → ADDIEX
  - any other opcode → FETCH, with `illegal_op`=1 for that DECODE cycle.
- MEMADR → MEMRD for lw, MEMWR for sw.
- MEMRD → MEMWB when `mem_ready`; otherwise stay.
- MEMWR → FETCH when `mem_ready`; otherwise stay.
- EXEC → ALUWB.
- ADDIEX → ADDIWB.
- MEMWB, ALUWB, ADDIWB, BRANCH, JUMP → FETCH.
- Unused state encodings → FETCH on the next edge, with all outputs 0 while in them.

## Timing
- Reset: a synchronous `rst` at an edge forces `state`=FETCH. While `rst` is high, every output is forced to 0, including `mem_req`.
- The first fetch request is issued in the first cycle after `rst` is sampled low.
- `rst` mid-instruction (including during a wait state) aborts the instruction. No write enable is asserted in the cycle `rst` is high.
- Memory handshake:
  - `mem_req` stays high, with `iord`, `mem_write` and the address held stable, until `mem_ready` is sampled high.
  - The access completes in the cycle both `mem_req` and `mem_ready` are high.
  - `mem_ready` is ignored when `mem_req`=0.
- Cycles per instruction with zero wait states:
  - lw: 5
  - sw: 4
  - R-type: 4
  - addi: 4
  - beq: 3
  - j: 3
  - illegal opcode: 2
- Each memory wait cycle adds one cycle.
- `opcode` is sampled only in DECODE and MEMADR.

## Configuration
- `MC_CTRL_ADDI_EN` defined: opcode 001000 follows DECODE → ADDIEX → ADDIWB.
- `MC_CTRL_ADDI_EN` undefined: ADDIEX and ADDIWB are not built, and opcode 001000 is handled as illegal (`illegal_op` pulse, return to FETCH).

## Structure
- Package `mips_mc_pkg` holds:
  - the state enumeration (4-bit)
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_J, OP_ADDI)
  - `alu_op` constants (ALUOP_ADD=00, ALUOP_SUB=01, ALUOP_FUNCT=10)
  - `alu_src_b` and `pc_src` select constants.
- One sub-module, `mc_ctrl_decode`: a combinational state-to-control-word decoder. The FSM top holds only the state register, next-state logic and the `rst` gating.

## Test plan
- Reset then lw with `mem_ready`=1: state sequence FETCH, DECODE, MEMADR, MEMRD, MEMWB, FETCH. `reg_write`=1 and `mem_to_reg`=1 only in the 5th cycle.
- R-type (opcode 000000): `alu_op`=10 in EXEC, `reg_dst`=1 in ALUWB, back in FETCH after 4 cycles. Then beq: `alu_op`=01 and `branch`=1 in cycle 3.
- sw with `mem_ready` low for 3 cycles in MEMWR: `mem_req`=1, `mem_write`=1 and `iord`=1 held stable for 4 cycles, then FETCH. The instruction takes 7 cycles.
- FETCH with `mem_ready`=0 for 2 cycles: `ir_write`=`pc_write`=0 until `mem_ready`=1, then exactly one cycle of both high.
- Opcode 111111: `illegal_op`=1 for one DECODE cycle, FETCH next. Opcode 001000 gives ADDIEX/ADDIWB with `MC_CTRL_ADDI_EN`, and `illegal_op` without it.
- `rst` asserted in MEMRD during a wait: all outputs 0 that cycle, FETCH next, no `reg_write` ever asserted for the aborted lw.
